// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations through execute and the load pipe,
// drives forwarding selects and operand register enables, stalls on load-use and squashes after taken branches.
module hazard_ctrl #(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_A_addr,
  input  logic [3:0]  id_B_addr,
  input  logic [3:0]  id_shift_addr,
  input  logic        id_use_A,
  input  logic        id_use_B,
  input  logic        id_use_shift,
  input  logic [3:0]  id_w_addr,
  input  logic        id_w_en,
  input  logic        id_is_ldr,
  input  logic        branch_taken,
  output logic [1:0]  sel_A_in,
  output logic [1:0]  sel_B_in,
  output logic [1:0]  sel_shift_in,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        id_ready,
  output logic [3:0]  ex_w_addr,
  output logic        ex_w_en,
  output logic [15:0] ldr_pend,
  output logic [15:0] stall_cnt
);

  logic                ex_valid;
  logic [3:0]          ex_w_addr_q;
  logic                ex_w_en_q;
  logic                ex_is_ldr;
  logic [LOAD_LAT-1:0] ldr_vld;
  logic [3:0]          ldr_addr [LOAD_LAT];
  logic [1:0]          flush_cnt;

  logic squash;
  logic stall;
  logic ex_ldr;
  logic live_a, live_b, live_s;

  assign squash    = (flush_cnt != 2'd0) | branch_taken;
  assign ex_ldr    = ex_valid & ex_w_en_q & ex_is_ldr;
  assign ex_w_en   = ex_valid & ex_w_en_q & ~ex_is_ldr;
  assign ex_w_addr = ex_w_addr_q;

  assign live_a = id_use_A & id_valid;
  assign live_b = id_use_B & id_valid;
  assign live_s = id_use_shift & id_valid;

  // The last slot still counts: its regfile write lands at the end of that cycle, with no load-path forward.
  always_comb begin
    ldr_pend = 16'h0000;
    if (ex_ldr)
      ldr_pend[ex_w_addr_q] = 1'b1;
    for (int i = 0; i < LOAD_LAT; i++)
      if (ldr_vld[i])
        ldr_pend[ldr_addr[i]] = 1'b1;
  end

  assign stall = (live_a & ldr_pend[id_A_addr]) |
                 (live_b & ldr_pend[id_B_addr]) |
                 (live_s & ldr_pend[id_shift_addr]);

  // Squash overrides stall so wrong-path instructions drain out of decode.
  assign id_ready = ~stall | squash;
  assign en_A     = id_ready & id_valid & ~squash;
  assign en_B     = en_A;
  assign en_S     = en_A;

  always_comb begin
    sel_A_in = 2'b00;
    if (live_a) begin
      if (id_A_addr == 4'd15)
        sel_A_in = 2'b11;
      else if (ex_w_en && id_A_addr == ex_w_addr_q)
        sel_A_in = 2'b01;
    end
  end

  always_comb begin
    sel_B_in = 2'b00;
    if (live_b && ex_w_en && id_B_addr == ex_w_addr_q)
      sel_B_in = 2'b01;
  end

  // Select 11 on the shift operand feeds a zero shift amount.
  always_comb begin
    sel_shift_in = 2'b11;
    if (live_s)
      sel_shift_in = (ex_w_en && id_shift_addr == ex_w_addr_q) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_w_addr_q <= 4'd0;
      ex_w_en_q   <= 1'b0;
      ex_is_ldr   <= 1'b0;
    end else if (id_ready && !squash) begin
      ex_valid    <= id_valid;
      ex_w_addr_q <= id_w_addr;
      ex_w_en_q   <= id_w_en;
      ex_is_ldr   <= id_is_ldr;
    end else begin
      ex_valid    <= 1'b0;
      ex_w_addr_q <= 4'd0;
      ex_w_en_q   <= 1'b0;
      ex_is_ldr   <= 1'b0;
    end
  end

  // Load pipe never stalls or flushes: loads already past execute always complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldr_vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++)
        ldr_addr[i] <= 4'd0;
    end else begin
      ldr_vld[0]  <= ex_ldr;
      ldr_addr[0] <= ex_w_addr_q;
      for (int i = 1; i < LOAD_LAT; i++) begin
        ldr_vld[i]  <= ldr_vld[i-1];
        ldr_addr[i] <= ldr_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flush_cnt <= 2'd0;
    else if (branch_taken)
      flush_cnt <= 2'(FLUSH_CYCLES);
    else if (flush_cnt != 2'd0)
      flush_cnt <= flush_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= 16'h0000;
    else if (stall && !squash && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with default LOAD_LAT=2, FLUSH_CYCLES=2.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_A_addr, id_B_addr, id_shift_addr, id_w_addr;
  logic        id_use_A, id_use_B, id_use_shift, id_w_en, id_is_ldr;
  logic        branch_taken;
  logic [1:0]  sel_A_in, sel_B_in, sel_shift_in;
  logic        en_A, en_B, en_S, id_ready, ex_w_en;
  logic [3:0]  ex_w_addr;
  logic [15:0] ldr_pend, stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.LOAD_LAT(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_A_addr(id_A_addr), .id_B_addr(id_B_addr), .id_shift_addr(id_shift_addr),
    .id_use_A(id_use_A), .id_use_B(id_use_B), .id_use_shift(id_use_shift),
    .id_w_addr(id_w_addr), .id_w_en(id_w_en), .id_is_ldr(id_is_ldr),
    .branch_taken(branch_taken),
    .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
    .en_A(en_A), .en_B(en_B), .en_S(en_S), .id_ready(id_ready),
    .ex_w_addr(ex_w_addr), .ex_w_en(ex_w_en),
    .ldr_pend(ldr_pend), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                       input logic ua, input logic ub, input logic us,
                       input logic [3:0] w, input logic we, input logic ldr);
    id_valid = v; id_A_addr = a; id_B_addr = b; id_shift_addr = s;
    id_use_A = ua; id_use_B = ub; id_use_shift = us;
    id_w_addr = w; id_w_en = we; id_is_ldr = ldr;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken = 1'b0;
    idle();
    settle();
    check("rst_ldr_pend", ldr_pend, 16'h0000);
    check("rst_stall_cnt", stall_cnt, 16'h0000);
    check("rst_ex_w_en", 16'(ex_w_en), 16'h0000);
    check("rst_ex_w_addr", 16'(ex_w_addr), 16'h0000);
    check("rst_id_ready", 16'(id_ready), 16'h0001);
    check("rst_sel_shift", 16'(sel_shift_in), 16'h0003);
    rst_n = 1'b1;

    // ALU back-to-back forwarding
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    settle();
    check("alu_issue_en_A", 16'(en_A), 16'h0001);
    tick();
    drive(1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    settle();
    check("fwd_sel_A", 16'(sel_A_in), 16'h0001);
    check("fwd_sel_B", 16'(sel_B_in), 16'h0001);
    check("fwd_sel_shift", 16'(sel_shift_in), 16'h0001);
    check("fwd_id_ready", 16'(id_ready), 16'h0001);
    check("fwd_ex_w_addr", 16'(ex_w_addr), 16'h0003);
    check("fwd_ex_w_en", 16'(ex_w_en), 16'h0001);

    // PC source and unused shift operand
    tick();
    drive(1'b1, 4'd15, 4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    check("pc_ex_w_en_off", 16'(ex_w_en), 16'h0000);
    check("pc_sel_A", 16'(sel_A_in), 16'h0003);
    check("pc_sel_B", 16'(sel_B_in), 16'h0000);
    check("pc_sel_shift_zero", 16'(sel_shift_in), 16'h0003);

    // Load-use: LDR r5 then a B read of r5
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
    settle();
    check("ldr_issue_ready", 16'(id_ready), 16'h0001);
    tick();
    drive(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    check("lu_ex_pend", ldr_pend, 16'h0020);
    check("lu_ex_w_en_ldr", 16'(ex_w_en), 16'h0000);
    check("lu_stall1", 16'(id_ready), 16'h0000);
    check("lu_en_B1", 16'(en_B), 16'h0000);
    tick();
    settle();
    check("lu_stall2", 16'(id_ready), 16'h0000);
    check("lu_slot0_pend", ldr_pend, 16'h0020);
    tick();
    settle();
    check("lu_stall3", 16'(id_ready), 16'h0000);
    tick();
    settle();
    check("lu_release_ready", 16'(id_ready), 16'h0001);
    check("lu_release_en_B", 16'(en_B), 16'h0001);
    check("lu_sel_B", 16'(sel_B_in), 16'h0000);
    check("lu_pend_clear", ldr_pend, 16'h0000);
    check("lu_stall_cnt", stall_cnt, 16'd3);

    // Taken branch squashes 1 + FLUSH_CYCLES decode slots
    tick();
    drive(1'b1, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0);
    branch_taken = 1'b1;
    settle();
    check("br_en_A0", 16'(en_A), 16'h0000);
    check("br_en_S0", 16'(en_S), 16'h0000);
    check("br_ready0", 16'(id_ready), 16'h0001);
    tick();
    branch_taken = 1'b0;
    settle();
    check("br_en_B1", 16'(en_B), 16'h0000);
    check("br_ex_w_en1", 16'(ex_w_en), 16'h0000);
    tick();
    settle();
    check("br_en_A2", 16'(en_A), 16'h0000);
    check("br_ex_w_en2", 16'(ex_w_en), 16'h0000);
    tick();
    settle();
    check("br_en_A3", 16'(en_A), 16'h0001);
    check("br_ex_w_en3", 16'(ex_w_en), 16'h0000);
    tick();
    idle();
    settle();
    check("br_issue_ex_w_en", 16'(ex_w_en), 16'h0001);
    check("br_issue_ex_w_addr", 16'(ex_w_addr), 16'h0007);

    // Branch arriving during a load-use stall
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    check("sq_stall_ready", 16'(id_ready), 16'h0000);
    tick();
    branch_taken = 1'b1;
    settle();
    check("sq_ready", 16'(id_ready), 16'h0001);
    check("sq_en_A", 16'(en_A), 16'h0000);
    check("sq_stall_cnt", stall_cnt, 16'd4);
    tick();
    branch_taken = 1'b0;
    settle();
    check("sq_stall_cnt_hold", stall_cnt, 16'd4);
    check("sq_pend_slot1", ldr_pend, 16'h0040);
    check("sq_ready_drain", 16'(id_ready), 16'h0001);
    tick();
    idle();
    tick();
    settle();
    check("sq_pend_done", ldr_pend, 16'h0000);
    check("sq_stall_cnt_end", stall_cnt, 16'd4);

    // Asynchronous reset with a load in execute
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1);
    tick();
    idle();
    #1;
    check("ar_pend_before", ldr_pend, 16'h0020);
    rst_n = 1'b0;
    #1;
    check("ar_pend", ldr_pend, 16'h0000);
    check("ar_stall_cnt", stall_cnt, 16'h0000);
    check("ar_ex_w_en", 16'(ex_w_en), 16'h0000);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    check("ar_read_ready", 16'(id_ready), 16'h0001);
    check("ar_read_en_B", 16'(en_B), 16'h0001);
    tick();
    settle();
    check("ar_pend_after", ldr_pend, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the ARM32 datapath, sitting between decode and the datapath.
- Tracks in-flight destination registers across the execute stage and a fixed-latency LDR stage.
- Drives the datapath operand-forwarding selects and the A/B/S register enables.
- Stalls decode on load-use hazards and squashes wrong-path instructions after a taken branch.

Parameters:
LOAD_LAT, 2, cycles from LDR leaving execute until its w_en_ldr regfile write (1..4)
FLUSH_CYCLES, 2, decode slots squashed after branch_taken (1..3)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode holds a valid instruction
id_A_addr  input  4  decode A source register
id_B_addr  input  4  decode B source register
id_shift_addr  input  4  decode shift-amount source register
id_use_A  input  1  instruction reads A
id_use_B  input  1  instruction reads B
id_use_shift  input  1  instruction reads a shift register
id_w_addr  input  4  destination register
id_w_en  input  1  instruction writes id_w_addr
id_is_ldr  input  1  destination is written by the load path, not ALU
branch_taken  input  1  execute-stage instruction is writing PC this cycle
sel_A_in  output  2  datapath A forwarding select
sel_B_in  output  2  datapath B forwarding select
sel_shift_in  output  2  datapath shift forwarding select
en_A  output  1  load A register
en_B  output  1  load B register
en_S  output  1  load S register
id_ready  output  1  decode may advance (not stalled)
ex_w_addr  output  4  execute-stage destination, drives w_addr2
ex_w_en  output  1  execute-stage ALU write enable, drives w_en2
ldr_pend  output  16  one-hot bitmap of registers with an outstanding load
stall_cnt  output  16  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0) clears the following: ex_valid, ex_w_en, ex_w_addr=0, the LDR pipe (all slots invalid), the flush counter, stall_cnt, and ldr_pend.
- Execute stage: a register set {ex_valid, ex_w_addr, ex_w_en, ex_is_ldr}.
  - Loaded from decode when id_ready=1 and no squash is active.
  - Otherwise loaded with a bubble (ex_valid=0).
- ex_w_en output = ex_valid & ex_w_en & ~ex_is_ldr.
- LDR pipe: a LOAD_LAT-deep shift register of {valid, addr}.
  - Slot 0 is loaded when ex_valid & ex_w_en & ex_is_ldr.
  - The entry retires after the last slot; the regfile write happens that cycle.
- ldr_pend = OR of one-hot(addr) over valid slots, plus the execute-stage LDR.
- A source S is live when its use flag is 1 and id_valid=1.
- Stall (comb) = any live source whose address bit is set in ldr_pend.
  - id_ready = ~stall.
  - en_A = en_B = en_S = id_ready & id_valid & ~squash.
- Forwarding selects per live source, in priority order:
  - addr==15 on A → 2'b11 (PC).
  - Else ex_w_en output=1 and addr==ex_w_addr → 2'b01 (ALU_out).
  - Else 2'b00.
- A non-live shift source → sel_shift_in=2'b11 (zero).
- sel_B_in never drives 2'b11.
- Outputs are combinational from current state and inputs, so selects are valid in the same cycle as en_*.
- Branch handling:
  - branch_taken=1 loads the flush counter with FLUSH_CYCLES.
  - squash = (counter≠0) | branch_taken. While squash=1:
    - The execute stage loads a bubble.
    - en_* = 0.
    - id_ready = 1, so wrong-path instructions drain.
  - The counter decrements each cycle to 0.
  - A branch_taken during an active flush reloads the counter.
- Squash has priority over stall; a squashed instruction never stalls.
- The LDR pipe keeps advancing during stall and squash; in-flight loads are never cancelled.
- stall_cnt increments on each cycle with stall=1 & ~squash, saturating at 16'hFFFF.
- Simultaneous events:
  - A retiring LDR entry and a new ex→slot-0 LDR to the same register leave the bit set.
  - A register present in both the execute (ALU) stage and the LDR pipe: stall wins.

Test Plan:
1. ALU back-to-back: instr1 writes r3 (ALU); next cycle instr2 reads A=r3 → sel_A_in=01, id_ready=1, ex_w_addr=3, ex_w_en=1.
2. Load-use, LOAD_LAT=2: LDR r5, then instr reads B=r5 → id_ready=0 for 3 cycles (ex + 2 slots), en_B=0, stall_cnt=3; then sel_B_in=00 and issue proceeds.
3. PC source: id_A_addr=15, use_A=1 → sel_A_in=11; id_use_shift=0 → sel_shift_in=11.
4. Branch: branch_taken pulsed with FLUSH_CYCLES=2 → en_A/en_B/en_S=0 and ex_valid=0 for 3 cycles (pulse + 2), ex_w_en=0 throughout.
5. Reset mid-load: assert rst_n=0 with ldr_pend=16'h0020 → ldr_pend=0, stall_cnt=0, ex_w_en=0 asynchronously; after release, a read of r5 issues with no stall.
6. Squash over stall: load-use stall active, then branch_taken=1 → id_ready=1, en_*=0 same cycle, stall_cnt does not increment.
